// File: rtl/fc_output_layer.sv
// Final classifier layer: MACs N_IN activations against 10 ROM weights per input,
// adds per-class bias and emits 10 packed signed scores with a one-cycle valid pulse.
module fc_output_layer #(
  parameter int N_IN      = 64,
  parameter int IN_WIDTH  = 16,
  parameter int W_WIDTH   = 16,
  parameter int ACC_WIDTH = 36,
  parameter int AW        = $clog2(N_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [IN_WIDTH-1:0]     in_data,
  output logic                    in_ready,
  output logic [AW-1:0]           w_addr,
  input  logic [10*W_WIDTH-1:0]   w_data,
  input  logic [10*ACC_WIDTH-1:0] bias,
  output logic [10*ACC_WIDTH-1:0] layer_out,
  output logic                    valid
);

  localparam int NC = 10;
  localparam int PW = IN_WIDTH + W_WIDTH;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FLUSH = 2'd1,
    EMIT  = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic [AW-1:0]                count_q, count_d;
  logic signed [IN_WIDTH-1:0]   x_q, x_d;
  logic                         mac_pend_q, mac_pend_d;
  logic signed [ACC_WIDTH-1:0]  acc_q [NC];
  logic signed [ACC_WIDTH-1:0]  acc_d [NC];
  logic [NC*ACC_WIDTH-1:0]      layer_out_q, layer_out_d;
  logic                         valid_q, valid_d;

  logic                         accept;
  logic signed [PW-1:0]         prod [NC];

  assign in_ready  = (state_q == ACCUM) && !rst;
  assign accept    = in_valid && in_ready;
  // count returns to 0 on the last accept, so the ROM sees address 0 in FLUSH/EMIT
  assign w_addr    = count_q;
  assign layer_out = layer_out_q;
  assign valid     = valid_q;

  always_comb begin
    for (int j = 0; j < NC; j++) begin
      prod[j] = PW'(x_q) * PW'($signed(w_data[W_WIDTH*j +: W_WIDTH]));
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    x_d         = x_q;
    mac_pend_d  = accept;
    layer_out_d = layer_out_q;
    valid_d     = 1'b0;
    for (int j = 0; j < NC; j++) begin
      acc_d[j] = acc_q[j];
    end

    if (accept) begin
      x_d = $signed(in_data);
      if (count_q == AW'(N_IN - 1)) begin
        count_d = '0;
        state_d = FLUSH;
      end else begin
        count_d = count_q + AW'(1);
      end
    end

    // Weights for the registered activation arrive one cycle after its accept
    if (mac_pend_q) begin
      for (int j = 0; j < NC; j++) begin
        acc_d[j] = acc_q[j] + ACC_WIDTH'(prod[j]);
      end
    end

    case (state_q)
      FLUSH: state_d = EMIT;
      EMIT: begin
        for (int j = 0; j < NC; j++) begin
          layer_out_d[ACC_WIDTH*j +: ACC_WIDTH] =
            acc_q[j] + $signed(bias[ACC_WIDTH*j +: ACC_WIDTH]);
          acc_d[j] = '0;
        end
        valid_d = 1'b1;
        state_d = ACCUM;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      count_q     <= '0;
      x_q         <= '0;
      mac_pend_q  <= 1'b0;
      layer_out_q <= '0;
      valid_q     <= 1'b0;
      for (int j = 0; j < NC; j++) begin
        acc_q[j] <= '0;
      end
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      x_q         <= x_d;
      mac_pend_q  <= mac_pend_d;
      layer_out_q <= layer_out_d;
      valid_q     <= valid_d;
      for (int j = 0; j < NC; j++) begin
        acc_q[j] <= acc_d[j];
      end
    end
  end

endmodule

// File: tb/tb_fc_output_layer.sv
// Bench for fc_output_layer: a 4-input and a 64-input instance share one weight
// table and bias vector; scores are checked against a plain dot-product model.
module tb_fc_output_layer;

  localparam int IW = 16;
  localparam int WW = 16;
  localparam int SW = 36;
  localparam int NC = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NC*WW-1:0] wm [64];
  logic [NC*SW-1:0] bias_v;
  int               xs [64];

  logic              in_valid4 = 1'b0, in_valid64 = 1'b0;
  logic [IW-1:0]     in_data4 = '0, in_data64 = '0;
  logic              in_ready4, in_ready64;
  logic [1:0]        w_addr4;
  logic [5:0]        w_addr64;
  logic [NC*WW-1:0]  w_data4 = '0, w_data64 = '0;
  logic [NC*SW-1:0]  layer_out4, layer_out64;
  logic              valid4, valid64;

  int n_cmp = 0;
  int n_bad = 0;

  fc_output_layer #(.N_IN(4), .IN_WIDTH(IW), .W_WIDTH(WW), .ACC_WIDTH(SW)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_data(in_data4),
    .in_ready(in_ready4), .w_addr(w_addr4), .w_data(w_data4), .bias(bias_v),
    .layer_out(layer_out4), .valid(valid4)
  );

  fc_output_layer #(.N_IN(64), .IN_WIDTH(IW), .W_WIDTH(WW), .ACC_WIDTH(SW)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid64), .in_data(in_data64),
    .in_ready(in_ready64), .w_addr(w_addr64), .w_data(w_data64), .bias(bias_v),
    .layer_out(layer_out64), .valid(valid64)
  );

  // Synchronous weight ROMs
  always @(posedge clk) begin
    w_data4  <= wm[{4'd0, w_addr4}];
    w_data64 <= wm[w_addr64];
  end

  // Score for class j of a frame whose activations are xs[base .. base+n-1]
  function automatic logic [SW-1:0] ref_score(input int j, input int base, input int n);
    longint s;
    s = longint'($signed(bias_v[SW*j +: SW]));
    for (int i = 0; i < n; i++) begin
      s += longint'(xs[base+i]) * longint'($signed(wm[i][WW*j +: WW]));
    end
    return s[SW-1:0];
  endfunction

  task automatic randomize_params(input int n);
    for (int a = 0; a < n; a++) begin
      for (int j = 0; j < NC; j++) wm[a][WW*j +: WW] = 16'($urandom);
    end
    for (int j = 0; j < NC; j++) bias_v[SW*j +: SW] = 36'({$urandom(), $urandom()});
  endtask

  // mode 0: in_valid held high, 1: toggles 1/0, 2: random gaps
  task automatic drive_frame(input int sel, input int base, input int n, input int mode);
    int i = 0;
    int cyc = 0;
    logic rdy, v;
    while (i < n && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 1) : ($urandom_range(0, 1) == 1);
      if (sel == 0) begin
        in_valid4 = v; in_data4 = 16'(xs[base+i]); rdy = in_ready4;
      end else begin
        in_valid64 = v; in_data64 = 16'(xs[base+i]); rdy = in_ready64;
      end
      @(posedge clk);
      if (v && rdy) i++;
    end
    if (i < n) begin
      n_cmp++; n_bad++;
      $display("FAIL drive_timeout: accepted %0d of %0d activations", i, n);
    end
  endtask

  // Number of negedge samples after the last accept edge until valid is seen (-1 = none)
  task automatic wait_valid(input int sel, output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      in_valid4 = 1'b0;
      in_valid64 = 1'b0;
      if ((sel == 0 ? valid4 : valid64) === 1'b1) begin
        lat = k;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (in_ready4 !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready4); end
    n_cmp++; if (valid4 !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid4); end
    n_cmp++; if (layer_out4 !== '0) begin n_bad++; $display("FAIL reset_layer_out: got %h want 0", layer_out4); end
    n_cmp++; if (w_addr4 !== 2'd0) begin n_bad++; $display("FAIL reset_w_addr: got %0d want 0", w_addr4); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready4 !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready4); end
  endtask

  task automatic run_and_check(input string tag, input int mode);
    int lat;
    drive_frame(0, 0, 4, mode);
    wait_valid(0, lat);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL %s_latency: got %0d want 3", tag, lat); end
    n_cmp++; if (in_ready4 !== 1'b1) begin n_bad++; $display("FAIL %s_ready_in_valid_cycle: got %b want 1", tag, in_ready4); end
    for (int j = 0; j < NC; j++) begin
      n_cmp++;
      if (layer_out4[SW*j +: SW] !== ref_score(j, 0, 4)) begin
        n_bad++;
        $display("FAIL %s_score%0d: got %h want %h", tag, j, layer_out4[SW*j +: SW], ref_score(j, 0, 4));
      end
    end
    @(negedge clk);
    n_cmp++; if (valid4 !== 1'b0) begin n_bad++; $display("FAIL %s_valid_width: got %b want 0", tag, valid4); end
  endtask

  task automatic test_basic();
    for (int a = 0; a < 4; a++) begin
      xs[a] = a + 1;
      for (int j = 0; j < NC; j++) wm[a][WW*j +: WW] = 16'(j);
    end
    bias_v = '0;
    run_and_check("basic", 0);
    for (int j = 0; j < NC; j++) begin
      n_cmp++;
      if (layer_out4[SW*j +: SW] !== 36'(10 * j)) begin
        n_bad++; $display("FAIL basic_const%0d: got %0d want %0d", j, layer_out4[SW*j +: SW], 10 * j);
      end
    end
  endtask

  task automatic test_signed_and_gaps();
    randomize_params(4);
    xs[0] = -3; xs[1] = 5; xs[2] = -7; xs[3] = 2;
    for (int a = 0; a < 4; a++) begin
      wm[a][0 +: WW] = 16'hFFFF;
      wm[a][WW*9 +: WW] = 16'd32767;
    end
    bias_v[0 +: SW] = 36'd100;
    bias_v[SW*9 +: SW] = 36'(-1);
    run_and_check("signed", 0);
    n_cmp++; if (layer_out4[0 +: SW] !== 36'd103) begin n_bad++; $display("FAIL signed_class0: got %0d want 103", layer_out4[0 +: SW]); end
    run_and_check("toggle", 1);
    for (int r = 0; r < 3; r++) begin
      randomize_params(4);
      for (int a = 0; a < 4; a++) xs[a] = $urandom_range(0, 65535) - 32768;
      run_and_check("random_gaps", 2);
    end
  endtask

  task automatic test_back_to_back();
    int i = 0;
    int pulses = 0;
    logic rdy, vld_now;
    logic first2_in_vld = 1'b0;
    logic [NC*SW-1:0] held = '0;
    randomize_params(4);
    for (int a = 0; a < 8; a++) xs[a] = $urandom_range(0, 65535) - 32768;
    for (int cyc = 0; cyc < 60 && pulses < 2; cyc++) begin
      @(negedge clk);
      vld_now = valid4;
      if (vld_now) begin
        pulses++;
        for (int j = 0; j < NC; j++) begin
          n_cmp++;
          if (layer_out4[SW*j +: SW] !== ref_score(j, (pulses - 1) * 4, 4)) begin
            n_bad++;
            $display("FAIL b2b_frame%0d_score%0d: got %h want %h", pulses, j,
                     layer_out4[SW*j +: SW], ref_score(j, (pulses - 1) * 4, 4));
          end
        end
        held = layer_out4;
      end else if (pulses == 1) begin
        n_cmp++;
        if (layer_out4 !== held) begin n_bad++; $display("FAIL b2b_hold: got %h want %h", layer_out4, held); end
      end
      in_valid4 = (i < 8);
      in_data4 = 16'(xs[i < 8 ? i : 0]);
      rdy = in_ready4;
      @(posedge clk);
      if (in_valid4 && rdy) begin
        if (i == 4) first2_in_vld = vld_now;
        i++;
      end
    end
    in_valid4 = 1'b0;
    n_cmp++; if (pulses !== 2) begin n_bad++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
    n_cmp++; if (first2_in_vld !== 1'b1) begin n_bad++; $display("FAIL b2b_overlap: got %b want 1", first2_in_vld); end
  endtask

  task automatic test_mid_reset();
    drive_frame(0, 0, 2, 0);
    @(negedge clk);
    rst = 1'b1;
    in_valid4 = 1'b1;
    #1;
    n_cmp++; if (in_ready4 !== 1'b0) begin n_bad++; $display("FAIL midrst_in_ready: got %b want 0", in_ready4); end
    @(negedge clk);
    n_cmp++; if (layer_out4 !== '0) begin n_bad++; $display("FAIL midrst_layer_out: got %h want 0", layer_out4); end
    n_cmp++; if (valid4 !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b want 0", valid4); end
    in_valid4 = 1'b0;
    rst = 1'b0;
    randomize_params(4);
    for (int a = 0; a < 4; a++) xs[a] = $urandom_range(0, 65535) - 32768;
    run_and_check("after_reset", 0);
  endtask

  task automatic test_overflow();
    int lat;
    for (int r = 0; r < 2; r++) begin
      for (int a = 0; a < 64; a++) begin
        xs[a] = (r == 0) ? -32768 : ($urandom_range(0, 1) == 1 ? 32767 : -32768);
        for (int j = 0; j < NC; j++)
          wm[a][WW*j +: WW] = (r == 0) ? 16'h8000 : ($urandom_range(0, 1) == 1 ? 16'h7FFF : 16'h8000);
      end
      for (int j = 0; j < NC; j++) bias_v[SW*j +: SW] = {1'b0, {35{1'b1}}};
      drive_frame(1, 0, 64, 0);
      wait_valid(1, lat);
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL ovf%0d_latency: got %0d want 3", r, lat); end
      for (int j = 0; j < NC; j++) begin
        n_cmp++;
        if (layer_out64[SW*j +: SW] !== ref_score(j, 0, 64)) begin
          n_bad++;
          $display("FAIL ovf%0d_score%0d: got %h want %h", r, j, layer_out64[SW*j +: SW], ref_score(j, 0, 64));
        end
      end
    end
  endtask

  initial begin
    bias_v = '0;
    for (int a = 0; a < 64; a++) wm[a] = '0;
    for (int a = 0; a < 64; a++) xs[a] = 0;
    test_reset();
    test_basic();
    test_signed_and_gaps();
    test_back_to_back();
    test_mid_reset();
    test_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
